// File: rtl/addr_dec_resp_mux_vl.sv
// addr_dec_resp_mux_vl
//   Routes a single master request to one of NumOut slave ports selected by
//   add_i, and returns responses to the master strictly in grant order.
//   A tracking FIFO records {bank, miss} for every granted request that
//   expects a response. Only the FIFO head is serviced, so a slave whose
//   response is not at the head is held off with rready_o low.
//   Addresses at or above NumOut are decode misses: the block grants them
//   itself and later answers with err_o=1 and zero data.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/add_i/wen_i     master request, bank index, write enable
//   data_i                master request payload
//   gnt_o                 grant to master
//   vld_o/rready_i        response handshake towards master
//   rdata_o/err_o         response data, decode-miss error flag
//   cnt_o                 number of outstanding responses
//   req_o/gnt_i           per-slave request / grant
//   data_o                payload replicated to every slave
//   rvalid_i/rready_o     per-slave response handshake
//   rdata_i               per-slave response data
module addr_dec_resp_mux_vl #(
  parameter int NumOut         = 32,
  parameter int ReqDataWidth   = 32,
  parameter int RespDataWidth  = 32,
  parameter int MaxOutstanding = 4,
  parameter bit WriteRespOn    = 1'b1,
  localparam int AW = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int CW = $clog2(MaxOutstanding + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  input  logic [AW-1:0]                          add_i,
  input  logic                                   wen_i,
  input  logic [ReqDataWidth-1:0]                data_i,
  output logic                                   gnt_o,
  output logic                                   vld_o,
  input  logic                                   rready_i,
  output logic [RespDataWidth-1:0]               rdata_o,
  output logic                                   err_o,
  output logic [CW-1:0]                          cnt_o,
  output logic [NumOut-1:0]                      req_o,
  input  logic [NumOut-1:0]                      gnt_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]    data_o,
  input  logic [NumOut-1:0]                      rvalid_i,
  output logic [NumOut-1:0]                      rready_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i
);

  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Pointer advance with explicit wrap so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [AW-1:0] bank_idx;
  logic          in_range;
  logic          need_rsp;
  logic          full;
  logic          blk;
  logic          gnt_sel;
  logic          push;
  logic          pop;
  logic          empty;

  logic [AW-1:0] fifo_bank [MaxOutstanding];
  logic          fifo_miss [MaxOutstanding];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] head_bank;
  logic          head_miss;

  // Request side: decode and grant, purely combinational.
  // Blocking uses only the registered count, so a pop in the same cycle
  // never opens a path from the response side into gnt_o.
  always_comb begin
    bank_idx = (NumOut == 1) ? '0 : add_i;
    in_range = (NumOut == 1) || (32'(add_i) < 32'(NumOut));
    need_rsp = ~wen_i | WriteRespOn;
    full     = (cnt_q == CW'(MaxOutstanding));
    blk      = full & need_rsp;
    req_o    = '0;
    gnt_sel  = 1'b0;
    for (int i = 0; i < NumOut; i++) begin
      if (bank_idx == AW'(i)) begin
        req_o[i] = req_i & ~blk;
        gnt_sel  = gnt_i[i];
      end
    end
    gnt_o = in_range ? (gnt_sel & ~blk) : (req_i & ~blk);
    for (int i = 0; i < NumOut; i++) begin
      data_o[i] = data_i;
    end
  end

  assign push = req_i & gnt_o & need_rsp;
  assign pop  = vld_o & rready_i;

  // Tracking FIFO storage (payload only, not reset).
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_bank[wr_ptr] <= bank_idx;
      fifo_miss[wr_ptr] <= ~in_range;
    end
  end

  // Tracking FIFO control.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign cnt_o     = cnt_q;
  assign empty     = (cnt_q == '0);
  assign head_bank = fifo_bank[rd_ptr];
  assign head_miss = fifo_miss[rd_ptr];

  // Response side: only the head entry is visible to the master.
  always_comb begin
    vld_o    = 1'b0;
    err_o    = 1'b0;
    rdata_o  = '0;
    rready_o = '0;
    if (!empty) begin
      if (head_miss) begin
        vld_o = 1'b1;
        err_o = 1'b1;
      end else begin
        for (int i = 0; i < NumOut; i++) begin
          if (head_bank == AW'(i)) begin
            rready_o[i] = rready_i;
            vld_o       = rvalid_i[i];
            rdata_o     = rdata_i[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_dec_resp_mux_vl.sv
module tb_addr_dec_resp_mux_vl;
  localparam int NO = 5;
  localparam int AW = 3;
  localparam int MO = 3;
  localparam int CW = 2;
  localparam int DW = 32;
  localparam int RW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i, req_i, wen_i, rready_i;
  logic [AW-1:0]          add_i;
  logic [DW-1:0]          data_i;
  logic [NO-1:0]          gnt_i, rvalid_i;
  logic [NO-1:0][RW-1:0]  rdata_i;

  // Index 0: WriteRespOn=1, index 1: WriteRespOn=0; both see the same inputs.
  logic                   gnt_o    [2];
  logic                   vld_o    [2];
  logic                   err_o    [2];
  logic [RW-1:0]          rdata_o  [2];
  logic [CW-1:0]          cnt_o    [2];
  logic [NO-1:0]          req_o    [2];
  logic [NO-1:0]          rready_o [2];
  logic [NO-1:0][DW-1:0]  data_o   [2];

  addr_dec_resp_mux_vl #(
    .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
    .MaxOutstanding(MO), .WriteRespOn(1'b1)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .data_i(data_i), .gnt_o(gnt_o[0]), .vld_o(vld_o[0]), .rready_i(rready_i),
    .rdata_o(rdata_o[0]), .err_o(err_o[0]), .cnt_o(cnt_o[0]), .req_o(req_o[0]),
    .gnt_i(gnt_i), .data_o(data_o[0]), .rvalid_i(rvalid_i),
    .rready_o(rready_o[0]), .rdata_i(rdata_i)
  );

  addr_dec_resp_mux_vl #(
    .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
    .MaxOutstanding(MO), .WriteRespOn(1'b0)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .data_i(data_i), .gnt_o(gnt_o[1]), .vld_o(vld_o[1]), .rready_i(rready_i),
    .rdata_o(rdata_o[1]), .err_o(err_o[1]), .cnt_o(cnt_o[1]), .req_o(req_o[1]),
    .gnt_i(gnt_i), .data_o(data_o[1]), .rvalid_i(rvalid_i),
    .rready_o(rready_o[1]), .rdata_i(rdata_i)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of outstanding responses in grant order.
  int qb [2][$];
  bit qm [2][$];
  bit push_m [2];
  bit pop_m  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input int a, input bit w, input logic [NO-1:0] g,
                       input logic [NO-1:0] rv, input bit rr);
    req_i    = r;
    add_i    = AW'(a);
    wen_i    = w;
    gnt_i    = g;
    rvalid_i = rv;
    rready_i = rr;
  endtask

  task automatic eval_cycle();
    for (int d = 0; d < 2; d++) begin
      bit            wro, need, blk, inr, e_gnt, e_vld, e_err;
      int            cnt, h;
      logic [NO-1:0] e_req, e_rdy;
      logic [RW-1:0] e_rd;
      wro   = (d == 0);
      need  = !wen_i || wro;
      cnt   = qb[d].size();
      blk   = (cnt == MO) && need;
      inr   = (int'(add_i) < NO);
      e_req = '0;
      e_rdy = '0;
      e_rd  = '0;
      e_vld = 1'b0;
      e_err = 1'b0;
      if (inr) begin
        e_req[add_i] = req_i && !blk;
        e_gnt        = gnt_i[add_i] && !blk;
      end else begin
        e_gnt = req_i && !blk;
      end
      if (cnt > 0) begin
        if (qm[d][0]) begin
          e_vld = 1'b1;
          e_err = 1'b1;
        end else begin
          h        = qb[d][0];
          e_vld    = rvalid_i[h];
          e_rd     = rdata_i[h];
          e_rdy[h] = rready_i;
        end
      end
      chk($sformatf("u%0d.req_o", d),    req_o[d],    e_req);
      chk($sformatf("u%0d.gnt_o", d),    gnt_o[d],    e_gnt);
      chk($sformatf("u%0d.cnt_o", d),    cnt_o[d],    cnt);
      chk($sformatf("u%0d.vld_o", d),    vld_o[d],    e_vld);
      chk($sformatf("u%0d.err_o", d),    err_o[d],    e_err);
      chk($sformatf("u%0d.rdata_o", d),  rdata_o[d],  e_rd);
      chk($sformatf("u%0d.rready_o", d), rready_o[d], e_rdy);
      for (int s = 0; s < NO; s++)
        chk($sformatf("u%0d.data_o[%0d]", d, s), data_o[d][s], data_i);
      push_m[d] = req_i && e_gnt && need;
      pop_m[d]  = e_vld && rready_i;
    end
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step();
    #1;
    eval_cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_i) begin
        qb[d].delete();
        qm[d].delete();
      end else begin
        if (pop_m[d]) begin
          void'(qb[d].pop_front());
          void'(qm[d].pop_front());
        end
        if (push_m[d]) begin
          qb[d].push_back(int'(add_i));
          qm[d].push_back(int'(add_i) >= NO);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i  = 1'b1;
    data_i = 32'h1234_5678;
    for (int s = 0; s < NO; s++) rdata_i[s] = 32'h100 + s;
    drive(0, 0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_cnt", cnt_o[d], 0);
      chk("reset_vld", vld_o[d], 0);
      chk("reset_err", err_o[d], 0);
      chk("reset_rready", rready_o[d], 0);
    end
    step();

    // Single read to bank 2, response three cycles later.
    drive(1, 2, 0, 5'b00100, '0, 0);
    #1 chk("single_gnt", gnt_o[0], 1);
    step();
    drive(0, 0, 0, '0, '0, 0);
    #1 chk("single_cnt1", cnt_o[0], 1);
    step();
    step();
    rdata_i[2] = 32'hA5;
    drive(0, 0, 0, '0, 5'b00100, 1);
    #1;
    chk("single_rready", rready_o[0], 5'b00100);
    chk("single_rdata", rdata_o[0], 32'hA5);
    step();
    drive(0, 0, 0, '0, '0, 0);
    #1 chk("single_cnt0", cnt_o[0], 0);
    step();

    // Reordering: bank 1 slow, bank 3 fast.
    rdata_i[1] = 32'h11;
    rdata_i[3] = 32'h33;
    drive(1, 1, 0, 5'b00010, '0, 1);
    step();
    drive(1, 3, 0, 5'b01000, '0, 1);
    step();
    drive(0, 0, 0, '0, 5'b01000, 1);
    #1;
    chk("reord_hold3", rready_o[0][3], 0);
    chk("reord_novld", vld_o[0], 0);
    step();
    step();
    drive(0, 0, 0, '0, 5'b01010, 1);
    #1 chk("reord_first", rdata_o[0], 32'h11);
    step();
    #1 chk("reord_second", rdata_o[0], 32'h33);
    step();
    drive(0, 0, 0, '0, '0, 0);
    step();

    // Full stall, then a pop unblocks the next cycle only.
    for (int i = 0; i < MO; i++) begin
      drive(1, 0, 0, '1, '0, 0);
      step();
    end
    #1;
    chk("full_req", req_o[0], 0);
    chk("full_gnt", gnt_o[0], 0);
    chk("full_cnt", cnt_o[0], MO);
    step();
    drive(1, 0, 0, '1, 5'b00001, 1);
    #1 chk("full_samecycle_gnt", gnt_o[0], 0);
    step();
    drive(1, 0, 0, '1, '0, 0);
    #1 chk("full_next_gnt", gnt_o[0], 1);
    step();
    drive(0, 0, 0, '0, '1, 1);
    repeat (MO + 1) step();

    // Decode miss.
    drive(1, 6, 0, '0, '0, 0);
    #1;
    chk("miss_req", req_o[0], 0);
    chk("miss_gnt", gnt_o[0], 1);
    step();
    drive(0, 0, 0, '0, '0, 1);
    #1;
    chk("miss_vld", vld_o[0], 1);
    chk("miss_err", err_o[0], 1);
    chk("miss_rdata", rdata_o[0], 0);
    step();

    // Writes at full on both variants.
    for (int i = 0; i < MO; i++) begin
      drive(1, 0, 0, '1, '0, 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, '1, '0, 0);
      #1;
      chk("wr_norsp_gnt", gnt_o[1], 1);
      chk("wr_norsp_cnt", cnt_o[1], MO);
      chk("wr_norsp_vld", vld_o[1], 0);
      chk("wr_rsp_blocked", gnt_o[0], 0);
      step();
    end

    // Reset mid-flight with the FIFO full.
    drive(0, 0, 0, '0, '0, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_cnt", cnt_o[d], 0);
      chk("midrst_vld", vld_o[d], 0);
      chk("midrst_rready", rready_o[d], 0);
    end
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_i    = ($urandom_range(0, 199) == 0);
      req_i    = ($urandom_range(0, 9) < 7);
      add_i    = AW'($urandom_range(0, 7));
      wen_i    = ($urandom_range(0, 9) < 3);
      data_i   = $urandom;
      gnt_i    = NO'($urandom);
      rvalid_i = NO'($urandom);
      rready_i = ($urandom_range(0, 9) < 6);
      for (int s = 0; s < NO; s++) rdata_i[s] = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
